// File: rtl/fp_issue_wb_ctrl.sv
// fp_issue_wb_ctrl
// Issue and writeback controller for the two fixed-latency FP units
// (unit 0 = fadd_sub, unit 1 = fmul). A slot array tracks in-flight results
// by cycles-to-arrival. It stops RAW/WAW hazards and writeback collisions
// at issue time. Results are collected into one registered writeback port.
module fp_issue_wb_ctrl #(
    parameter int LAT0    = 3,
    parameter int LAT1    = 4,
    parameter int MAX_LAT = (LAT0 > LAT1) ? LAT0 : LAT1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_unit,
    input  logic [4:0]         in_rd,
    input  logic               in_fp_write,
    input  logic [14:0]        in_rs,
    input  logic [2:0]         in_rs_use,
    output logic [1:0]         start_o,
    output logic               en_o,
    output logic [MAX_LAT-1:0] clear_o,
    input  logic               flush_i,
    input  logic               wb_stall_i,
    input  logic [1:0]         res_valid_i,
    input  logic [31:0]        res_data0_i,
    input  logic [31:0]        res_data1_i,
    output logic               wb_valid,
    output logic [4:0]         wb_rd,
    output logic               wb_fp,
    output logic [31:0]        wb_data,
    output logic               err_o
);

    // Slot k holds the op whose result arrives k cycles from now.
    logic       slot_v_q    [1:MAX_LAT];
    logic [4:0] slot_rd_q   [1:MAX_LAT];
    logic       slot_fp_q   [1:MAX_LAT];
    logic       slot_unit_q [1:MAX_LAT];
    logic       slot_v_d    [1:MAX_LAT];
    logic [4:0] slot_rd_d   [1:MAX_LAT];
    logic       slot_fp_d   [1:MAX_LAT];
    logic       slot_unit_d [1:MAX_LAT];

    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q,    wb_rd_d;
    logic        wb_fp_q,    wb_fp_d;
    logic [31:0] wb_data_q,  wb_data_d;
    logic        err_q,      err_d;

    logic en_s;
    logic hazard_s;
    logic waw_s;
    logic slot_free_s;
    logic in_ready_s;
    logic issue_s;
    logic s1_miss_s;
    logic spurious_s;
    int   issue_lat_s;

    assign en_s        = ~wb_stall_i;
    assign issue_lat_s = in_unit ? LAT1 : LAT0;

    // Hazard, WAW and writeback-slot availability for the presented instruction.
    always_comb begin
        hazard_s    = 1'b0;
        waw_s       = 1'b0;
        slot_free_s = 1'b1;
        for (int k = 1; k <= MAX_LAT; k++) begin
            for (int j = 0; j < 3; j++) begin
                hazard_s = hazard_s | (slot_v_q[k] & slot_fp_q[k] & in_rs_use[j] &
                                       (in_rs[j*5 +: 5] == slot_rd_q[k]));
            end
            waw_s = waw_s | (slot_v_q[k] & (in_rd == slot_rd_q[k]) &
                             (in_fp_write == slot_fp_q[k]));
            // The slot one cycle behind ours would reach our landing slot
            // in the same cycle as the new op.
            slot_free_s = slot_free_s & ~(slot_v_q[k] & (k == issue_lat_s + 1));
        end
        for (int j = 0; j < 3; j++) begin
            hazard_s = hazard_s | (wb_valid_q & wb_fp_q & in_rs_use[j] &
                                   (in_rs[j*5 +: 5] == wb_rd_q));
        end
        waw_s = waw_s | (wb_valid_q & (in_rd == wb_rd_q) & (in_fp_write == wb_fp_q));
    end

    assign in_ready_s = en_s & ~flush_i & ~hazard_s & ~waw_s & slot_free_s;
    // Units share our reset, so no start pulse is sent while it is asserted.
    assign issue_s    = in_valid & in_ready_s & rst;

    // Next slot contents: flush clears, enable shifts and inserts, stall holds.
    always_comb begin
        for (int k = 1; k <= MAX_LAT; k++) begin
            slot_v_d[k]    = slot_v_q[k];
            slot_rd_d[k]   = slot_rd_q[k];
            slot_fp_d[k]   = slot_fp_q[k];
            slot_unit_d[k] = slot_unit_q[k];
        end
        if (flush_i) begin
            for (int k = 1; k <= MAX_LAT; k++) begin
                slot_v_d[k] = 1'b0;
            end
        end else if (en_s) begin
            for (int k = 1; k < MAX_LAT; k++) begin
                slot_v_d[k]    = slot_v_q[k+1];
                slot_rd_d[k]   = slot_rd_q[k+1];
                slot_fp_d[k]   = slot_fp_q[k+1];
                slot_unit_d[k] = slot_unit_q[k+1];
            end
            slot_v_d[MAX_LAT]    = 1'b0;
            slot_rd_d[MAX_LAT]   = 5'd0;
            slot_fp_d[MAX_LAT]   = 1'b0;
            slot_unit_d[MAX_LAT] = 1'b0;
            for (int k = 1; k <= MAX_LAT; k++) begin
                if (issue_s && (k == issue_lat_s)) begin
                    slot_v_d[k]    = 1'b1;
                    slot_rd_d[k]   = in_rd;
                    slot_fp_d[k]   = in_fp_write;
                    slot_unit_d[k] = in_unit;
                end else begin
                    slot_v_d[k]    = slot_v_d[k];
                end
            end
        end else begin
            slot_v_d[1] = slot_v_q[1];
        end
    end

    // Next writeback register and sticky protocol-error flag.
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_fp_d    = wb_fp_q;
        wb_data_d  = wb_data_q;
        if (flush_i) begin
            // Committed entry survives a flush; it is only retired if not stalled.
            wb_valid_d = wb_valid_q & ~en_s;
        end else if (en_s) begin
            if (slot_v_q[1]) begin
                wb_valid_d = 1'b1;
                wb_rd_d    = slot_rd_q[1];
                wb_fp_d    = slot_fp_q[1];
                wb_data_d  = slot_unit_q[1] ? res_data1_i : res_data0_i;
            end else begin
                wb_valid_d = 1'b0;
            end
        end else begin
            wb_valid_d = wb_valid_q;
        end

        s1_miss_s  = slot_v_q[1] & ~res_valid_i[slot_unit_q[1]];
        spurious_s = (res_valid_i[0] & ~(slot_v_q[1] & ~slot_unit_q[1])) |
                     (res_valid_i[1] & ~(slot_v_q[1] &  slot_unit_q[1]));
        err_d      = err_q | (en_s & ~flush_i & (s1_miss_s | spurious_s));
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= MAX_LAT; k++) begin
                slot_v_q[k]    <= 1'b0;
                slot_rd_q[k]   <= 5'd0;
                slot_fp_q[k]   <= 1'b0;
                slot_unit_q[k] <= 1'b0;
            end
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_fp_q    <= 1'b0;
            wb_data_q  <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            for (int k = 1; k <= MAX_LAT; k++) begin
                slot_v_q[k]    <= slot_v_d[k];
                slot_rd_q[k]   <= slot_rd_d[k];
                slot_fp_q[k]   <= slot_fp_d[k];
                slot_unit_q[k] <= slot_unit_d[k];
            end
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_fp_q    <= wb_fp_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_s;
    assign en_o     = en_s;
    assign start_o  = {issue_s & in_unit, issue_s & ~in_unit};
    assign clear_o  = flush_i ? {MAX_LAT{1'b1}} : {MAX_LAT{1'b0}};
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_fp    = wb_fp_q;
    assign wb_data  = wb_data_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_fp_issue_wb_ctrl.sv
// Directed bench for fp_issue_wb_ctrl with behavioural fixed-latency units.
module tb_fp_issue_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_unit = 1'b0;
    logic [4:0]  in_rd = 5'd0;
    logic        in_fp_write = 1'b1;
    logic [14:0] in_rs = 15'd0;
    logic [2:0]  in_rs_use = 3'd0;
    logic [1:0]  start_o;
    logic        en_o;
    logic [3:0]  clear_o;
    logic        flush_i = 1'b0;
    logic        wb_stall_i = 1'b0;
    logic [1:0]  res_valid_i;
    logic [31:0] res_data0_i;
    logic [31:0] res_data1_i;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_fp;
    logic [31:0] wb_data;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    // Behavioural units: operand data captured on start, shifted while enabled.
    logic [31:0] din0 = 32'd0;
    logic [31:0] din1 = 32'd0;
    logic        spur0 = 1'b0;
    logic [2:0]  p0_v;
    logic [3:0]  p1_v;
    logic [31:0] p0_d [3];
    logic [31:0] p1_d [4];

    always #5 clk = ~clk;

    fp_issue_wb_ctrl #(.LAT0(3), .LAT1(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_unit(in_unit), .in_rd(in_rd), .in_fp_write(in_fp_write),
        .in_rs(in_rs), .in_rs_use(in_rs_use), .start_o(start_o), .en_o(en_o),
        .clear_o(clear_o), .flush_i(flush_i), .wb_stall_i(wb_stall_i),
        .res_valid_i(res_valid_i), .res_data0_i(res_data0_i),
        .res_data1_i(res_data1_i), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_fp(wb_fp), .wb_data(wb_data), .err_o(err_o)
    );

    // Unit pipelines: reset by rst, cleared by clear_o, frozen when en_o is low.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            p0_v <= 3'd0;
            p1_v <= 4'd0;
        end else if (|clear_o) begin
            p0_v <= 3'd0;
            p1_v <= 4'd0;
        end else if (en_o) begin
            p0_v    <= {p0_v[1:0], start_o[0]};
            p1_v    <= {p1_v[2:0], start_o[1]};
            p0_d[0] <= din0;
            p0_d[1] <= p0_d[0];
            p0_d[2] <= p0_d[1];
            p1_d[0] <= din1;
            p1_d[1] <= p1_d[0];
            p1_d[2] <= p1_d[1];
            p1_d[3] <= p1_d[2];
        end
    end

    assign res_valid_i = {p1_v[3], p0_v[2] | spur0};
    assign res_data0_i = p0_d[2];
    assign res_data1_i = p1_d[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic u, input logic [4:0] rd, input logic [14:0] rs,
                       input logic [2:0] use_m, input logic [31:0] d);
        in_valid    = 1'b1;
        in_unit     = u;
        in_rd       = rd;
        in_fp_write = 1'b1;
        in_rs       = rs;
        in_rs_use   = use_m;
        if (u) din1 = d;
        else   din0 = d;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_rs_use = 3'd0;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] dat [3];
        dat[0] = 32'h3F800000;
        dat[1] = 32'h40000000;
        dat[2] = 32'h40400000;

        // Reset state; en_o/in_ready follow their equations during reset.
        #2;
        chk("rst_wbv", wb_valid, 32'd0);
        chk("rst_err", err_o, 32'd0);
        chk("rst_start", start_o, 32'd0);
        chk("rst_clear", clear_o, 32'd0);
        chk("rst_en", en_o, 32'd1);
        chk("rst_ready", in_ready, 32'd1);
        nxt();
        nxt();
        rst = 1'b1;

        // Independent unit-0 issues, wb at t+4.
        for (int t = 0; t < 8; t++) begin
            if (t < 3) drv(1'b0, 5'(t + 1), 15'd0, 3'd0, dat[t]);
            else       idle();
            mid();
            if (t < 3) chk("ind_start", start_o, 32'h1);
            chk("ind_wbv", wb_valid, (t >= 4 && t <= 6) ? 32'd1 : 32'd0);
            if (t >= 4 && t <= 6) begin
                chk("ind_rd", wb_rd, 32'(t - 3));
                chk("ind_fp", wb_fp, 32'd1);
                chk("ind_data", wb_data, dat[t-4]);
            end
            nxt();
        end
        chk("ind_err", err_o, 32'd0);

        // RAW on rs1 = 5: blocked through the wb cycle, issues at t = 5.
        drv(1'b0, 5'd5, 15'd0, 3'd0, 32'h0000AAAA);
        mid();
        chk("raw_first", in_ready, 32'd1);
        nxt();
        for (int t = 1; t <= 5; t++) begin
            drv(1'b0, 5'd6, {5'd0, 5'd0, 5'd5}, 3'b001, 32'h44444444);
            mid();
            chk("raw_ready", in_ready, (t == 5) ? 32'd1 : 32'd0);
            nxt();
        end
        idle();
        for (int t = 0; t < 8; t++) nxt();

        // Same sources but rs1 unused: issues at t = 1.
        drv(1'b0, 5'd5, 15'd0, 3'd0, 32'h0000BBBB);
        nxt();
        drv(1'b0, 5'd6, {5'd0, 5'd0, 5'd5}, 3'b000, 32'h0000CCCC);
        mid();
        chk("nouse_ready", in_ready, 32'd1);
        chk("nouse_start", start_o, 32'h1);
        nxt();
        idle();
        for (int t = 0; t < 8; t++) nxt();

        // Writeback collision: fmul at t0 blocks fadd at t1.
        drv(1'b1, 5'd7, 15'd0, 3'd0, 32'h11111111);
        mid();
        chk("col_start1", start_o, 32'h2);
        nxt();
        drv(1'b0, 5'd8, 15'd0, 3'd0, 32'h22222222);
        mid();
        chk("col_block", in_ready, 32'd0);
        chk("col_nostart", start_o, 32'd0);
        nxt();
        mid();
        chk("col_issue", in_ready, 32'd1);
        chk("col_start0", start_o, 32'h1);
        nxt();
        idle();
        for (int t = 3; t < 8; t++) begin
            mid();
            chk("col_wbv", wb_valid, (t == 5 || t == 6) ? 32'd1 : 32'd0);
            if (t == 5) begin
                chk("col_rd5", wb_rd, 32'd7);
                chk("col_data5", wb_data, 32'h11111111);
            end
            if (t == 6) begin
                chk("col_rd6", wb_rd, 32'd8);
                chk("col_data6", wb_data, 32'h22222222);
            end
            nxt();
        end
        chk("col_err", err_o, 32'd0);

        // Stall t=2..3 delays the result and writeback by two cycles.
        drv(1'b0, 5'd9, 15'd0, 3'd0, 32'h33333333);
        nxt();
        idle();
        nxt();
        for (int t = 2; t <= 3; t++) begin
            wb_stall_i = 1'b1;
            drv(1'b0, 5'd10, 15'd0, 3'd0, 32'h55555555);
            mid();
            chk("stl_en", en_o, 32'd0);
            chk("stl_ready", in_ready, 32'd0);
            chk("stl_start", start_o, 32'd0);
            nxt();
        end
        wb_stall_i = 1'b0;
        idle();
        mid();
        chk("stl_res4", res_valid_i, 32'd0);
        chk("stl_wbv4", wb_valid, 32'd0);
        nxt();
        mid();
        chk("stl_res5", res_valid_i, 32'h1);
        chk("stl_wbv5", wb_valid, 32'd0);
        nxt();
        mid();
        chk("stl_wbv6", wb_valid, 32'd1);
        chk("stl_rd6", wb_rd, 32'd9);
        chk("stl_data6", wb_data, 32'h33333333);
        nxt();
        mid();
        chk("stl_wbv7", wb_valid, 32'd0);
        nxt();

        // Stall during the wb cycle holds the wb outputs.
        drv(1'b0, 5'd11, 15'd0, 3'd0, 32'h66666666);
        nxt();
        idle();
        nxt();
        nxt();
        nxt();
        wb_stall_i = 1'b1;
        mid();
        chk("hold_wbv4", wb_valid, 32'd1);
        nxt();
        wb_stall_i = 1'b0;
        mid();
        chk("hold_wbv5", wb_valid, 32'd1);
        chk("hold_rd5", wb_rd, 32'd11);
        chk("hold_data5", wb_data, 32'h66666666);
        nxt();
        mid();
        chk("hold_wbv6", wb_valid, 32'd0);
        nxt();

        // Flush with two ops in flight.
        drv(1'b0, 5'd12, 15'd0, 3'd0, 32'h77777777);
        nxt();
        drv(1'b1, 5'd13, 15'd0, 3'd0, 32'h88888888);
        mid();
        chk("fl_start1", start_o, 32'h2);
        nxt();
        flush_i = 1'b1;
        drv(1'b0, 5'd14, 15'd0, 3'd0, 32'h99999999);
        mid();
        chk("fl_clear", clear_o, 32'hF);
        chk("fl_ready", in_ready, 32'd0);
        chk("fl_start", start_o, 32'd0);
        nxt();
        flush_i = 1'b0;
        idle();
        mid();
        chk("fl_clear0", clear_o, 32'd0);
        chk("fl_ready3", in_ready, 32'd1);
        for (int t = 3; t < 9; t++) begin
            mid();
            chk("fl_wbv", wb_valid, 32'd0);
            nxt();
        end
        chk("fl_err", err_o, 32'd0);

        // Reset with three ops in flight.
        for (int t = 0; t < 3; t++) begin
            drv(1'b0, 5'(15 + t), 15'd0, 3'd0, 32'h99990000 + 32'(t));
            nxt();
        end
        idle();
        rst = 1'b0;
        #1;
        chk("mr_wbv", wb_valid, 32'd0);
        chk("mr_rd", wb_rd, 32'd0);
        chk("mr_fp", wb_fp, 32'd0);
        chk("mr_data", wb_data, 32'd0);
        chk("mr_err", err_o, 32'd0);
        chk("mr_start", start_o, 32'd0);
        chk("mr_en", en_o, 32'd1);
        chk("mr_ready", in_ready, 32'd1);
        nxt();
        nxt();
        rst = 1'b1;
        for (int t = 0; t < 6; t++) begin
            mid();
            chk("mr_nowb", wb_valid, 32'd0);
            nxt();
        end
        chk("mr_err2", err_o, 32'd0);

        // Spurious unit-0 result sets the sticky error.
        spur0 = 1'b1;
        mid();
        chk("sp_err_pre", err_o, 32'd0);
        nxt();
        spur0 = 1'b0;
        mid();
        chk("sp_err", err_o, 32'd1);
        nxt();
        nxt();
        mid();
        chk("sp_sticky", err_o, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_issue_wb_ctrl.md
# fp_issue_wb_ctrl

Issue and writeback controller for the fixed-latency pipelined FP execution units: fadd_sub, with latency 3, and fmul, with latency LAT1.
- It accepts decoded FP instructions and checks RAW/WAW hazards against in-flight destinations.
- It reserves a collision-free writeback slot, drives each unit's `p_start`, `en` and per-stage `clear`, and collects each unit's `p_result`/result into a single registered writeback port.
- It sits between decode and the FP units, on the initiator side of the units' `p_start`/`p_result` protocol.

## Interface
Parameters:
- LAT0, 3, latency of unit 0 (fadd_sub): edges from `p_start` to `p_result`.
- LAT1, 4, latency of unit 1 (fmul).
- MAX_LAT, max(LAT0, LAT1), derived; number of slots and width of `clear_o`.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  decoded FP instruction present.
- in_ready  out  1  instruction accepted this cycle (issue = in_valid & in_ready).
- in_unit  in  1  target unit: 0 = fadd_sub, 1 = fmul.
- in_rd  in  5  destination register.
- in_fp_write  in  1  destination is the FP regfile (0 = integer regfile).
- in_rs  in  15  {rs3, rs2, rs1}, FP sources.
- in_rs_use  in  3  per-source valid.
- start_o  out  2  `p_start` per unit, one-hot, high only on issue.
- en_o  out  1  global enable to both units.
- clear_o  out  MAX_LAT  per-stage clear, broadcast to both units; each unit uses its low LAT bits.
- flush_i  in  1  kill all in-flight operations.
- wb_stall_i  in  1  writeback port cannot accept this cycle.
- res_valid_i  in  2  `p_result` per unit.
- res_data0_i, res_data1_i  in  32  unit results.
- wb_valid  out  1  writeback valid.
- wb_rd  out  5  writeback register.
- wb_fp  out  1  writeback targets the FP regfile.
- wb_data  out  32  writeback data.
- err_o  out  1  sticky protocol error.

## Operation
Slot array s[1..MAX_LAT], each slot holding {v, rd, fp, unit}; s[k] means the result arrives in k cycles.

Per-cycle sequence when en_o = 1 and flush_i = 0:
- Shift: s[k] <= s[k+1]; s[MAX_LAT] <= empty.
- Issue to unit u writes s[LAT_u] <= {1, in_rd, in_fp_write, u}.
- s[1] valid: capture res_data of s[1].unit into the wb register with rd/fp; wb_valid <= 1. Otherwise wb_valid <= 0.

Issue conditions:
- slot_free(u) = (LAT_u == MAX_LAT) | ~s[LAT_u+1].v.
- hazard = any used rs equal to rd of a valid slot with fp=1, or of the wb register when wb_valid & wb_fp.
- WAW: in_rd equal to rd of any valid slot or valid wb entry with the same fp flag.
- in_ready = en_o & ~flush_i & ~hazard & ~waw & slot_free(in_unit); combinational.
- start_o[in_unit] = in_valid & in_ready.

Stall, flush and errors:
- en_o = ~wb_stall_i.
- While stalled, slots, the wb register and the units all freeze; wb outputs hold their values.
- flush_i (priority over stall and issue): all slots invalidated, clear_o = all ones that cycle, no issue.
- On flush the wb register is kept (already committed) and held if stalled; otherwise wb_valid <= 0 next edge.
- clear_o = 0 when flush_i = 0.
- err_o set (sticky until reset) when, with en_o = 1 and no flush, either:
  - s[1].v & ~res_valid_i[s[1].unit], or
  - res_valid_i[u] with no s[1] entry for u.

## Timing
- Reset values (asynchronous): slots empty, wb_valid 0, wb_rd 0, wb_fp 0, wb_data 0, err_o 0, start_o 0, clear_o 0.
- en_o and in_ready follow their equations during reset: with no stall, en_o = 1 and in_ready = 1.
- Issue at cycle t (en high) gives res_valid_i at t+LAT_u and wb_valid at t+LAT_u+1, plus one cycle per stalled cycle.
- Throughput is one issue per cycle; at most one wb per cycle, guaranteed by slot_free.
- A dependent instruction issues at the earliest at t+LAT_u+2, after the regfile write at the end of the wb cycle. There is no bypass.
- Reset mid-flight drops all entries: no wb after release, and the units are reset by the same rst.
- Flush and issue in the same cycle: the issue is suppressed (in_ready = 0).
- Stall and result arrival in the same cycle: nothing is lost, because the units are frozen by en_o.

## Test plan
- Independent unit-0 issues rd = 1, 2, 3 at t = 0, 1, 2 with data 0x3F800000, 0x40000000, 0x40400000 -> wb_valid at t = 4, 5, 6 with matching rd/data; err_o = 0.
- Unit-0 issue rd = 5 at t = 0, next instruction uses rs1 = 5 -> in_ready low t = 1..4, issue at t = 5; same with in_rs_use[0] = 0 -> issue at t = 1.
- Unit-1 issue at t = 0, unit-0 issue requested at t = 1 (both would land at t = 4) -> in_ready = 0 at t = 1, issue at t = 2, wb at t = 5 and t = 6.
- Unit-0 issue at t = 0, wb_stall_i high t = 2..3 -> en_o low t = 2..3, res_valid_i at t = 5, wb_valid at t = 6; start_o low while stalled.
- Two ops in flight, flush_i at t = 2 -> clear_o = all ones for one cycle, no wb for either op, in_ready = 1 at t = 3, err_o = 0.
- rst low at t = 2 with three ops in flight -> all outputs at reset values immediately, no wb_valid after release; force a spurious res_valid_i[0] -> err_o = 1 the next cycle.
